// File: rtl/ramen_order_arbiter.sv
// ramen_order_arbiter: round-robin share of one ramen kitchen between N counters, with end-of-day close
module ramen_order_arbiter #(
  parameter int N = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] req_type,
  input  logic [N-1:0]   req_portion,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   done,
  output logic           done_success,
  input  logic           close_req,
  output logic           close_done,
  output logic           busy,
  output logic           err_timeout,
  output logic           k_in_valid,
  output logic           k_selling,
  output logic [1:0]     k_ramen_type,
  output logic           k_portion,
  input  logic           k_out_valid_order,
  input  logic           k_success,
  input  logic           k_out_valid_tot
);
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SEND_TYPE, SEND_PORTION, WAIT_RESULT, CLOSE, WAIT_TOT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, pick, cand;
  logic [1:0] type_q, type_d;
  logic portion_q, portion_d, close_q, close_d, hit;
  logic [TW-1:0] timer_q, timer_d;
  logic [N-1:0] done_q, done_d, ack_c, elig;
  logic done_success_q, done_success_d, close_done_q, close_done_d, err_q, err_d;
  // A counter whose done is pulsing this cycle is skipped so ack and done never coincide
  assign elig = req & ~done_q;
  // Round-robin search: descending loop so the candidate closest to the pointer wins
  always_comb begin
    pick = '0;
    cand = '0;
    hit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (elig[cand]) begin
        pick = cand;
        hit = 1'b1;
      end
    end
  end
  // Next-state logic and kitchen-side outputs
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    type_d = type_q;
    portion_d = portion_q;
    close_d = close_q | close_req;
    timer_d = timer_q;
    done_d = '0;
    done_success_d = 1'b0;
    close_done_d = 1'b0;
    err_d = err_q;
    ack_c = '0;
    k_in_valid = 1'b0;
    k_selling = 1'b1;
    k_ramen_type = 2'd0;
    k_portion = 1'b0;
    case (state_q)
      IDLE: begin
        if (close_q) state_d = CLOSE;
        else if (hit) begin
          ack_c[pick] = 1'b1;
          idx_d = pick;
          type_d = req_type[2*int'(pick) +: 2];
          portion_d = req_portion[pick];
          ptr_d = IW'((int'(pick) + 1) % N);
          state_d = SEND_TYPE;
        end
      end
      SEND_TYPE: begin
        k_in_valid = 1'b1;
        k_ramen_type = type_q;
        state_d = SEND_PORTION;
      end
      SEND_PORTION: begin
        k_in_valid = 1'b1;
        k_portion = portion_q;
        timer_d = '0;
        state_d = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        if (k_out_valid_order || timer_q == TW'(TIMEOUT - 1)) begin
          done_d[idx_q] = 1'b1;
          done_success_d = k_out_valid_order & k_success;
          err_d = err_q | ~k_out_valid_order;
          state_d = IDLE;
        end else timer_d = timer_q + 1'b1;
      end
      CLOSE: begin
        k_selling = 1'b0;
        timer_d = '0;
        state_d = WAIT_TOT;
      end
      WAIT_TOT: begin
        if (k_out_valid_tot || timer_q == TW'(TIMEOUT - 1)) begin
          close_done_d = 1'b1;
          close_d = 1'b0;
          err_d = err_q | ~k_out_valid_tot;
          state_d = IDLE;
        end else timer_d = timer_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      type_q <= 2'd0;
      portion_q <= 1'b0;
      close_q <= 1'b0;
      timer_q <= '0;
      done_q <= '0;
      done_success_q <= 1'b0;
      close_done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      type_q <= type_d;
      portion_q <= portion_d;
      close_q <= close_d;
      timer_q <= timer_d;
      done_q <= done_d;
      done_success_q <= done_success_d;
      close_done_q <= close_done_d;
      err_q <= err_d;
    end
  end
  assign ack = rst ? '0 : ack_c;
  assign done = done_q;
  assign done_success = done_success_q;
  assign close_done = close_done_q;
  assign err_timeout = err_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_ramen_order_arbiter.sv
// tb_ramen_order_arbiter: directed scoreboard bench for the ramen order arbiter
module tb_ramen_order_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0, req_portion = '0;
  logic [2*N-1:0] req_type = '0;
  logic close_req = 1'b0, k_out_valid_order = 1'b0, k_success = 1'b0, k_out_valid_tot = 1'b0;
  logic [N-1:0] ack, done;
  logic done_success, close_done, busy, err_timeout, k_in_valid, k_selling, k_portion;
  logic [1:0] k_ramen_type;
  int ncmp = 0, nfail = 0;
  int ack_q[$], done_i_q[$];
  bit done_s_q[$];
  int ea, ed;
  bit es, got;

  ramen_order_arbiter #(.N(N), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_type(req_type), .req_portion(req_portion),
    .ack(ack), .done(done), .done_success(done_success), .close_req(close_req),
    .close_done(close_done), .busy(busy), .err_timeout(err_timeout),
    .k_in_valid(k_in_valid), .k_selling(k_selling), .k_ramen_type(k_ramen_type),
    .k_portion(k_portion), .k_out_valid_order(k_out_valid_order), .k_success(k_success),
    .k_out_valid_tot(k_out_valid_tot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant cycle already sampled; drop the request, let the kitchen answer at the earliest point
  task automatic run(input int i, input bit succ);
    tick();
    req[i] = 1'b0;
    tick();
    tick();
    k_out_valid_order = 1'b1;
    k_success = succ;
    tick();
    k_out_valid_order = 1'b0;
    k_success = 1'b0;
  endtask

  // Scoreboard: every ack and done pulse is matched against the queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (|ack) begin
        if (ack_q.size() == 0) check("ack_unexpected", 32'(ack), 0);
        else begin
          ea = ack_q.pop_front();
          check("ack_grant", 32'(ack), 32'(1) << ea);
        end
        check("ack_done_overlap", 32'(ack & done), 0);
      end
      if (|done) begin
        if (done_i_q.size() == 0) check("done_unexpected", 32'(done), 0);
        else begin
          ed = done_i_q.pop_front();
          es = done_s_q.pop_front();
          check("done_counter", 32'(done), 32'(1) << ed);
          check("done_success", 32'(done_success), 32'(es));
        end
      end
    end
  end

  initial begin
    req = 4'b0001;
    @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_selling", 32'(k_selling), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_valid", 32'(k_in_valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_close_done", 32'(close_done), 0);
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      ack_q.push_back(i);
      done_i_q.push_back(i);
      done_s_q.push_back(i[0]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run(i, i[0]);
    end
    req = 4'b1001;
    ack_q.push_back(0); done_i_q.push_back(0); done_s_q.push_back(1'b1);
    @(negedge clk);
    run(0, 1'b1);
    ack_q.push_back(3); done_i_q.push_back(3); done_s_q.push_back(1'b0);
    @(negedge clk);
    run(3, 1'b0);
    @(negedge clk);
    check("rr_err_clear", 32'(err_timeout), 0);
    check("rr_ack_left", 32'(ack_q.size()), 0);
    tick();
    req = 4'b0100;
    req_type = 8'b0011_0000;
    req_portion = 4'b0100;
    ack_q.push_back(2); done_i_q.push_back(2); done_s_q.push_back(1'b1);
    @(negedge clk);
    check("g_busy", 32'(busy), 0);
    tick();
    req = '0;
    req_type = '0;
    req_portion = '0;
    @(negedge clk);
    check("g1_valid", 32'(k_in_valid), 1);
    check("g1_type", 32'(k_ramen_type), 3);
    check("g1_portion", 32'(k_portion), 0);
    check("g1_busy", 32'(busy), 1);
    tick();
    @(negedge clk);
    check("g2_valid", 32'(k_in_valid), 1);
    check("g2_type", 32'(k_ramen_type), 0);
    check("g2_portion", 32'(k_portion), 1);
    tick();
    @(negedge clk);
    check("g3_valid", 32'(k_in_valid), 0);
    tick();
    k_out_valid_order = 1'b1;
    k_success = 1'b1;
    @(negedge clk);
    check("g4_done", 32'(done), 0);
    tick();
    k_out_valid_order = 1'b0;
    k_success = 1'b0;
    @(negedge clk);
    check("g5_done", 32'(done), 32'h4);
    check("g5_idle", 32'(busy), 0);
    tick();
    req = 4'b0010;
    ack_q.push_back(1); done_i_q.push_back(1); done_s_q.push_back(1'b0);
    @(negedge clk);
    tick();
    req = '0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      @(negedge clk);
      got = |done;
    end
    check("timeout_seen", 32'(got), 1);
    tick();
    @(negedge clk);
    check("timeout_err", 32'(err_timeout), 1);
    tick();
    req = 4'b0001;
    ack_q.push_back(0); done_i_q.push_back(0); done_s_q.push_back(1'b1);
    @(negedge clk);
    tick();
    req = 4'b0010;
    tick();
    close_req = 1'b1;
    tick();
    close_req = 1'b0;
    tick();
    k_out_valid_order = 1'b1;
    k_success = 1'b1;
    tick();
    k_out_valid_order = 1'b0;
    k_success = 1'b0;
    @(negedge clk);
    check("cl_done_ack", 32'(ack), 0);
    check("cl_done_sell", 32'(k_selling), 1);
    tick();
    @(negedge clk);
    check("cl_close_sell", 32'(k_selling), 0);
    check("cl_close_ack", 32'(ack), 0);
    check("cl_close_busy", 32'(busy), 1);
    tick();
    k_out_valid_order = 1'b1;
    close_req = 1'b1;
    @(negedge clk);
    check("cl_wait_sell", 32'(k_selling), 1);
    check("cl_wait_ack", 32'(ack), 0);
    tick();
    k_out_valid_order = 1'b0;
    close_req = 1'b0;
    k_out_valid_tot = 1'b1;
    @(negedge clk);
    check("cl_tot_pending", 32'(close_done), 0);
    tick();
    k_out_valid_tot = 1'b0;
    ack_q.push_back(1); done_i_q.push_back(1); done_s_q.push_back(1'b1);
    @(negedge clk);
    check("cl_close_done", 32'(close_done), 1);
    run(1, 1'b1);
    @(negedge clk);
    check("cl_close_done_pulse", 32'(close_done), 0);
    check("cl_err_sticky", 32'(err_timeout), 1);
    tick();
    tick();
    @(negedge clk);
    check("cl_no_reclose", 32'(busy), 0);
    check("cl_left", 32'(ack_q.size() + done_i_q.size()), 0);
    tick();
    req = 4'b0100;
    ack_q.push_back(2);
    @(negedge clk);
    tick();
    req = '0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    req = 4'b1001;
    #1;
    check("mr_busy", 32'(busy), 0);
    check("mr_selling", 32'(k_selling), 1);
    check("mr_err", 32'(err_timeout), 0);
    check("mr_ack", 32'(ack), 0);
    check("mr_valid", 32'(k_in_valid), 0);
    tick();
    tick();
    rst = 1'b0;
    ack_q.push_back(0); done_i_q.push_back(0); done_s_q.push_back(1'b1);
    @(negedge clk);
    check("mr_done_none", 32'(done), 0);
    run(0, 1'b1);
    ack_q.push_back(3); done_i_q.push_back(3); done_s_q.push_back(1'b0);
    @(negedge clk);
    run(3, 1'b0);
    tick();
    @(negedge clk);
    check("end_left", 32'(ack_q.size() + done_i_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/ramen_order_arbiter.md
Name: ramen_order_arbiter

Overview:
- Shares one ramen kitchen engine between N ordering counters.
- Grants pending orders round-robin and serialises each one into the kitchen's two-cycle order protocol (type, then portion).
- Waits for the kitchen's verdict and routes it back to the counter that placed the order.
- Sequences end-of-day close: deasserts selling and collects the kitchen's totals handshake.

Parameters:
- N, 4: number of ordering counters (2..8).
- TIMEOUT, 16: maximum cycles to wait for kitchen verdict/totals before aborting.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N  per-counter order request; held high until ack.
- req_type  in  2N  ramen type of counter i at [2i+1:2i] (0 tonkotsu, 1 tonkotsu-soy, 2 miso, 3 miso-soy).
- req_portion  in  N  portion of counter i (0 small, 1 big).
- ack  out  N  one-cycle pulse: counter i's order captured.
- done  out  N  one-cycle pulse: counter i's order resolved.
- done_success  out  1  verdict, valid with any done bit.
- close_req  in  1  pulse: end of selling session requested.
- close_done  out  1  one-cycle pulse: kitchen totals received.
- busy  out  1  high in every state except IDLE.
- err_timeout  out  1  sticky flag; set on any timeout, cleared only by rst.
- k_in_valid  out  1  kitchen order valid.
- k_selling  out  1  kitchen selling flag.
- k_ramen_type  out  2  kitchen ramen type.
- k_portion  out  1  kitchen portion.
- k_out_valid_order  in  1  kitchen verdict valid.
- k_success  in  1  kitchen verdict.
- k_out_valid_tot  in  1  kitchen totals valid.

Behaviour:
- Reset values:
  - All outputs 0, except k_selling = 1.
  - State IDLE, rr pointer 0, close pending 0, timer 0, err_timeout 0.
- States: IDLE, SEND_TYPE, SEND_PORTION, WAIT_RESULT, CLOSE, WAIT_TOT.
- IDLE:
  - If close pending: go to CLOSE. Close has priority over any req.
  - Else if any req: pick the first set req[i] searching upward from rr pointer, wrapping.
  - Latch i, type and portion. Pulse ack[i] in the same cycle. Set rr pointer = (i+1) mod N. Go to SEND_TYPE.
- SEND_TYPE: k_in_valid = 1, k_selling = 1, k_ramen_type = latched type, k_portion = 0. Go to SEND_PORTION.
- SEND_PORTION: k_in_valid = 1, k_selling = 1, k_portion = latched portion, k_ramen_type = 0. Clear timer. Go to WAIT_RESULT.
- WAIT_RESULT:
  - k_in_valid = 0. Timer increments each cycle.
  - On k_out_valid_order: pulse done[i], done_success = k_success on the next cycle, return to IDLE.
  - If timer reaches TIMEOUT first: pulse done[i], done_success = 0, set err_timeout, return to IDLE.
- CLOSE (one cycle): k_selling = 0, k_in_valid = 0. Clear timer. Go to WAIT_TOT.
- WAIT_TOT:
  - k_selling = 1.
  - On k_out_valid_tot: pulse close_done next cycle, clear close pending, go to IDLE.
  - On timer reaching TIMEOUT: same, and set err_timeout.
- close_req:
  - Latched into close pending in any state.
  - An in-flight order completes before the close begins.
  - A second close_req while pending has no effect.
- Reqs during close are not acked; they stay pending and are served after IDLE is re-entered. The rr pointer is retained across close.
- Stray k_out_valid_order or k_out_valid_tot outside its wait state is ignored.
- done and ack never coincide for the same counter. Minimum order turnaround is 4 cycles (grant, type, portion, verdict).
- req_type and req_portion are sampled only in the grant cycle. Later changes do not affect the in-flight order.
- Reset mid-operation: immediate return to reset values. No done is issued for the aborted order.

Test Plan:
- Single order: req[2] = 1, type 3, portion 1.
  -> ack[2] at grant cycle G.
  -> k_in_valid at G+1 (type 3) and G+2 (portion 1).
  -> kitchen responds success = 1 at G+4 -> done[2] = 1, done_success = 1 at G+5.
- Round-robin: req = 4'b1111 held, each counter drops its req after ack.
  -> ack order 0,1,2,3.
  -> re-raise req[0] and req[3] -> next grant 0 (pointer wrapped to 0), then 3.
- Failure: kitchen returns k_success = 0 -> done[i] with done_success = 0, err_timeout stays 0.
- Timeout: no k_out_valid_order for 16 cycles after SEND_PORTION -> done[i], done_success = 0, err_timeout = 1 sticky.
- Close during order: close_req pulsed at G+2 while req[1] also pending.
  -> current order finishes.
  -> k_selling = 0 for exactly one cycle, no ack[1] yet.
  -> kitchen raises k_out_valid_tot -> close_done pulse.
  -> then ack[1].
- Reset mid-WAIT_RESULT: rst = 1 -> all outputs 0, k_selling = 1, no done pulse, next req granted from counter 0 priority.
